// File: rtl/fifo_arbmod.sv
// fifo_arbmod
// Write arbiter and read sequencer placed in front of a 16-deep fifo_savemod.
// Two producers share the FIFO write port under round-robin arbitration. One
// consumer reads through a request/accept handshake. FIFO iEn/iData are driven
// from registers. Occupancy is tracked locally because the FIFO flags lag the
// registered writes by one cycle.
//
// Handshake semantics:
//   - A producer raises iReq[n] and holds it, with iData_n stable, until
//     oAck[n] is high. The word is taken in the cycle where oAck[n]=1.
//   - The consumer raises iRdReq. A word is accepted in any cycle where
//     oRdAck=1. Its data appears on oRdData two cycles later, with oRdValid=1.
//
// Ports:
//   CLOCK, RESET            clock (rising edge), synchronous active-high reset
//   iReq, iData0, iData1    producer requests and write data
//   oAck                    one-cycle grant pulse per producer (combinational)
//   iRdReq, oRdAck          consumer read request / accept (combinational)
//   oRdData, oRdValid       read data (= iFifoData) and its valid strobe
//   oEn, oFifoData          registered FIFO iEn ([1] write, [0] read) / iData
//   iFifoData, iTag         FIFO oData / oTag ([1] full, [0] empty)
//   oCount                  local occupancy, 0..DEPTH
//   oErr                    sticky overflow/underflow indication
//
// FIFO_ARB_FIXPRIO_EN selects fixed-priority arbitration with requester 0
// first and no pointer state.
module fifo_arbmod #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [1:0]        iReq,
    input  logic [DATA_W-1:0] iData0,
    input  logic [DATA_W-1:0] iData1,
    output logic [1:0]        oAck,
    input  logic              iRdReq,
    output logic              oRdAck,
    output logic [DATA_W-1:0] oRdData,
    output logic              oRdValid,
    output logic [1:0]        oEn,
    output logic [DATA_W-1:0] oFifoData,
    input  logic [DATA_W-1:0] iFifoData,
    input  logic [1:0]        iTag,
    output logic [CNT_W-1:0]  oCount,
    output logic              oErr
);

    logic [1:0]        grant;
    logic              rdAck;
    logic              notFull;
    logic              notEmpty;
    logic [DATA_W-1:0] grantData;

    assign notFull  = (oCount != CNT_W'(DEPTH));
    assign notEmpty = (oCount != '0);

`ifdef FIFO_ARB_FIXPRIO_EN
    // Fixed priority: producer 0 always wins. There is no arbitration state.
    always_comb begin
        grant = 2'b00;
        if (!RESET && notFull) begin
            if (iReq[0]) begin
                grant = 2'b01;
            end else if (iReq[1]) begin
                grant = 2'b10;
            end
        end
    end
`else
    // Round-robin pointer: rr names the preferred requester when both request.
    logic rr;
    logic rrNext;

    // Pointer register.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rr <= 1'b0;
        end else begin
            rr <= rrNext;
        end
    end

    // Next pointer: after any grant, prefer the requester that was not served.
    always_comb begin
        rrNext = rr;
        if (grant != 2'b00) begin
            rrNext = grant[0];
        end
    end

    // Grant decode.
    always_comb begin
        grant = 2'b00;
        if (!RESET && notFull) begin
            case (iReq)
                2'b11:   grant = rr ? 2'b10 : 2'b01;
                default: grant = iReq;
            endcase
        end
    end
`endif

    // A read is never accepted at count 0, even with a write granted in the same
    // cycle. That word only reaches the RAM one edge later.
    assign rdAck     = !RESET && iRdReq && notEmpty;
    assign oAck      = grant;
    assign oRdAck    = rdAck;
    assign oRdData   = iFifoData;
    assign grantData = grant[1] ? iData1 : iData0;

    // FIFO drive, read-valid pipeline (oEn[0] is its first stage) and occupancy.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            oEn       <= 2'b00;
            oFifoData <= '0;
            oRdValid  <= 1'b0;
            oCount    <= '0;
        end else begin
            oEn      <= {grant != 2'b00, rdAck};
            oRdValid <= oEn[0];
            if (grant != 2'b00) begin
                oFifoData <= grantData;
            end
            case ({grant != 2'b00, rdAck})
                2'b10:   oCount <= oCount + CNT_W'(1);
                2'b01:   oCount <= oCount - CNT_W'(1);
                default: oCount <= oCount;
            endcase
        end
    end

    // Sticky error: a write issued into a full FIFO or a read from an empty one.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            oErr <= 1'b0;
        end else if ((oEn[1] && iTag[1]) || (oEn[0] && iTag[0])) begin
            oErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_arbmod.sv
// Bench for fifo_arbmod. A behavioural FIFO stands in for fifo_savemod. The
// reference model tracks occupancy, the preferred requester, and a queue of
// stored words. Pipelined outputs are predicted from that queue.
module tb_fifo_arbmod;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    logic              CLOCK = 1'b0;
    logic              RESET = 1'b1;
    logic [1:0]        iReq = 2'b00;
    logic [DATA_W-1:0] iData0 = '0;
    logic [DATA_W-1:0] iData1 = '0;
    logic [1:0]        oAck;
    logic              iRdReq = 1'b0;
    logic              oRdAck;
    logic [DATA_W-1:0] oRdData;
    logic              oRdValid;
    logic [1:0]        oEn;
    logic [DATA_W-1:0] oFifoData;
    logic [DATA_W-1:0] iFifoData;
    logic [1:0]        iTag;
    logic [CNT_W-1:0]  oCount;
    logic              oErr;

    fifo_arbmod #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .iReq(iReq), .iData0(iData0),
        .iData1(iData1), .oAck(oAck), .iRdReq(iRdReq), .oRdAck(oRdAck),
        .oRdData(oRdData), .oRdValid(oRdValid), .oEn(oEn),
        .oFifoData(oFifoData), .iFifoData(iFifoData), .iTag(iTag),
        .oCount(oCount), .oErr(oErr)
    );

    // Clock.
    always #5 CLOCK = ~CLOCK;

    // Behavioural FIFO: registered oData, flags from its own count.
    // tagForce lets a test present false flags to exercise the error path.
    logic [DATA_W-1:0] fMem [DEPTH];
    logic [DATA_W-1:0] fOut = '0;
    int                fWp = 0, fRp = 0, fCnt = 0;
    logic [1:0]        tagForce = 2'b00;

    assign iFifoData = fOut;
    assign iTag      = {(fCnt == DEPTH) | tagForce[1], (fCnt == 0) | tagForce[0]};

    always @(posedge CLOCK) begin
        if (RESET) begin
            fWp  <= 0;
            fRp  <= 0;
            fCnt <= 0;
            fOut <= '0;
        end else begin
            if (oEn[1]) begin
                fMem[fWp] <= oFifoData;
                fWp       <= (fWp + 1) % DEPTH;
            end
            if (oEn[0]) begin
                fOut <= fMem[fRp];
                fRp  <= (fRp + 1) % DEPTH;
            end
            fCnt <= fCnt + int'(oEn[1]) - int'(oEn[0]);
        end
    end

    // Stimulus state: producers hold a pending word until acked.
    logic              rstNext = 1'b1;
    logic [1:0]        pend = 2'b00;
    logic [DATA_W-1:0] pd0 = '0, pd1 = '0;
    logic              rdReq = 1'b0;

    // Reference model.
    int                mCount = 0;
    logic              mRr = 1'b0;
    logic [DATA_W-1:0] exp_q [$];
    logic              prevW = 1'b0;
    logic [DATA_W-1:0] prevWData = '0;
    logic              v0 = 1'b0, v1 = 1'b0;
    logic [DATA_W-1:0] d0 = '0, d1 = '0;
    logic              expErr = 1'b0;

    int numVectors = 0;
    int numMiscompares = 0;
    int dutAcks = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numVectors++;
        if (got !== exp) begin
            numMiscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check all outputs against the model, then advance
    // the model across the edge.
    task automatic runCycle();
        logic [1:0]        eg;
        logic              era;
        logic [DATA_W-1:0] wd;
        @(negedge CLOCK);
        RESET  = rstNext;
        iReq   = pend;
        iData0 = pd0;
        iData1 = pd1;
        iRdReq = rdReq;
        #1;
        eg = 2'b00;
        if (!rstNext && mCount < DEPTH) begin
`ifdef FIFO_ARB_FIXPRIO_EN
            if (pend[0]) eg = 2'b01;
            else if (pend[1]) eg = 2'b10;
`else
            if (pend == 2'b11) eg = mRr ? 2'b10 : 2'b01;
            else eg = pend;
`endif
        end
        era = !rstNext && rdReq && (mCount > 0);
        checkVal("ack", 32'(oAck), 32'(eg));
        checkVal("rdAck", 32'(oRdAck), 32'(era));
        checkVal("count", 32'(oCount), 32'(mCount));
        checkVal("en", 32'(oEn), 32'({prevW, v0}));
        checkVal("rdValid", 32'(oRdValid), 32'(v1));
        checkVal("err", 32'(oErr), 32'(expErr));
        if (prevW) checkVal("fifoData", 32'(oFifoData), 32'(prevWData));
        if (v1) checkVal("rdData", 32'(oRdData), 32'(d1));
        if (oAck != 2'b00) dutAcks++;
        @(posedge CLOCK);
        if (rstNext) begin
            mCount = 0;
            mRr    = 1'b0;
            exp_q.delete();
            prevW  = 1'b0;
            v0     = 1'b0;
            v1     = 1'b0;
            expErr = 1'b0;
        end else begin
            if ((prevW && tagForce[1]) || (v0 && tagForce[0])) expErr = 1'b1;
            v1 = v0;
            d1 = d0;
            v0 = era;
            if (era) d0 = exp_q.pop_front();
            prevW = (eg != 2'b00);
            if (eg != 2'b00) begin
                if (eg[0]) begin
                    wd = pd0;
                    pend[0] = 1'b0;
                end else begin
                    wd = pd1;
                    pend[1] = 1'b0;
                end
                prevWData = wd;
                exp_q.push_back(wd);
                mRr = eg[0];
            end
            mCount = mCount + int'(eg != 2'b00) - int'(era);
        end
    endtask

    task automatic doReset();
        rstNext = 1'b1;
        pend    = 2'b00;
        rdReq   = 1'b0;
        runCycle();
        runCycle();
        rstNext = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) runCycle();
    endtask

    initial begin
        int nextVal;
        doReset();

        // Single write then a read of A5.
        pend = 2'b01; pd0 = 8'hA5;
        runCycle();
        rdReq = 1'b1;
        runCycle();
        rdReq = 1'b0;
        idle(4);

        // Both producers requesting: grant order 0 then 1, readback 10, 20.
        doReset();
        pend = 2'b11; pd0 = 8'h10; pd1 = 8'h20;
        idle(3);
        rdReq = 1'b1;
        idle(3);
        rdReq = 1'b0;
        idle(3);

        // Continuous writes 0..19 with no reads: only 16 are taken.
        doReset();
        dutAcks = 0;
        nextVal = 0;
        for (int i = 0; i < 30; i++) begin
            if (!pend[0] && nextVal < 20) begin
                pend[0] = 1'b1;
                pd0 = DATA_W'(nextVal);
                nextVal++;
            end
            runCycle();
        end
        checkVal("fillAcks", 32'(dutAcks), 32'd16);
        checkVal("fullTag", 32'(iTag[1]), 32'd1);
        pend = 2'b00;
        rdReq = 1'b1;
        idle(16);
        rdReq = 1'b0;
        idle(3);
        checkVal("emptyTag", 32'(iTag[0]), 32'd1);

        // Full boundary: write and read together at count 16.
        pd0 = 8'h00;
        for (int i = 0; i < 17; i++) begin
            if (!pend[0]) begin
                pend[0] = 1'b1;
                pd0 = pd0 + 8'h11;
            end
            runCycle();
        end
        pend[0] = 1'b1; pd0 = 8'h77; rdReq = 1'b1;
        runCycle();
        rdReq = 1'b0;
        idle(3);
        rdReq = 1'b1;
        idle(20);
        rdReq = 1'b0;

        // Empty boundary: read held, a single write.
        rdReq = 1'b1;
        idle(2);
        pend[1] = 1'b1; pd1 = 8'h3C;
        idle(5);
        rdReq = 1'b0;

        // Reset while a read is in flight.
        pend = 2'b01; pd0 = 8'h5A;
        idle(2);
        rdReq = 1'b1;
        runCycle();
        rdReq = 1'b0;
        rstNext = 1'b1;
        runCycle();
        rstNext = 1'b0;
        idle(3);

        // Randomized traffic: write-heavy, then read-heavy, rare resets.
        for (int i = 0; i < 1500; i++) begin
            int wp;
            int rp;
            wp = (i < 750) ? 70 : 35;
            rp = (i < 750) ? 35 : 70;
            if (!pend[0] && $urandom_range(0, 99) < wp) begin
                pend[0] = 1'b1; pd0 = DATA_W'($urandom);
            end
            if (!pend[1] && $urandom_range(0, 99) < wp) begin
                pend[1] = 1'b1; pd1 = DATA_W'($urandom);
            end
            rdReq   = ($urandom_range(0, 99) < rp);
            rstNext = ($urandom_range(0, 299) == 0);
            runCycle();
        end
        rstNext = 1'b0;

        // Error path: a forced full flag during a write, then a forced empty
        // flag during a read. The error is sticky until reset.
        doReset();
        tagForce = 2'b10;
        pend = 2'b01; pd0 = 8'hE1;
        idle(3);
        tagForce = 2'b00;
        idle(2);
        doReset();
        pend = 2'b10; pd1 = 8'hE2;
        idle(3);
        tagForce = 2'b01;
        rdReq = 1'b1;
        runCycle();
        rdReq = 1'b0;
        idle(2);
        tagForce = 2'b00;
        idle(2);
        doReset();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule

// File: doc/fifo_arbmod.md
# fifo_arbmod

Write-arbiter and read sequencer for the 16-deep, 8-bit `fifo_savemod` buffer. Two producers share the FIFO write port through round-robin arbitration, and one consumer reads through a request/valid handshake. The block drives the FIFO's `iEn`/`iData` from registers and tracks occupancy locally, so overflow and underflow cannot occur. Writes are issued with one cycle of latency and the FIFO's flags would lag, which is why a local count is required. The block sits directly in front of `fifo_savemod`, which is instantiated alongside it in the parent.

## Interface
- `DATA_W`, 8, data width; must match FIFO width.
- `DEPTH`, 16, FIFO capacity in words; local counter width is log2(DEPTH)+1.
- `CLOCK`  in  1  system clock, rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `iReq`  in  2  write request per producer; `iReq[n]` held with `iData_n` until `oAck[n]`.
- `iData0`, `iData1`  in  DATA_W  producer write data.
- `oAck`  out  2  one-cycle grant pulse; data is taken in that cycle.
- `iRdReq`  in  1  consumer read request, one word per accepted cycle.
- `oRdAck`  out  1  read accepted this cycle.
- `oRdData`  out  DATA_W  read data; equals `iFifoData`.
- `oRdValid`  out  1  `oRdData` valid this cycle.
- `oEn`  out  2  to FIFO `iEn`: [1] write, [0] read; registered.
- `oFifoData`  out  DATA_W  to FIFO `iData`; registered.
- `iFifoData`  in  DATA_W  from FIFO `oData`.
- `iTag`  in  2  from FIFO `oTag`: [1] full, [0] empty.
- `oCount`  out  log2(DEPTH)+1  local occupancy, 0..DEPTH.
- `oErr`  out  1  sticky protocol error.

## Operation
- **Write grant.** Grant goes to one requester per cycle, only when `oCount != DEPTH`.
  - Round-robin pointer `rr` (reset 0) names the preferred requester.
  - If both requesters are asserted, grant `rr`, then set `rr` to the other requester.
  - If only one requester is asserted, grant it, then set `rr` to the other requester.
  - With no grant, `rr` holds.
- **Write issue.** `oAck[n]` is combinational in the grant cycle. Next cycle: `oEn[1]=1`, `oFifoData` holds the granted data.
- **Read accept.** `oRdAck = iRdReq & (oCount != 0)`, combinational. Next cycle: `oEn[0]=1`.
- **Occupancy.** `oCount` changes on the edge ending the grant/accept cycle:
  - grant only: +1;
  - accept only: −1;
  - both in the same cycle: unchanged.
  - `oCount` can never exceed DEPTH or go below 0.
- **Full boundary.** When `oCount==DEPTH`, no grant is made even if a read is accepted in the same cycle. Requesters stall until the count drops.
- **Empty boundary.** When `oCount==0`, no read is accepted even if a write is granted in the same cycle.
- **Error.** `oErr` is set and held until reset if either occurs:
  - `oEn[1]` and `iTag[1]` are both high (overflow);
  - `oEn[0]` and `iTag[0]` are both high (underflow).
  - Never set in correct operation.

## Timing
- Reset (synchronous, `RESET=1` at an edge) clears:
  - outputs: `oEn=0`, `oFifoData=0`, `oCount=0`, `oRdValid=0`, `oErr=0`;
  - internal state: `rr=0`, read-valid pipeline.
  - `oAck` and `oRdAck` are 0 while `RESET=1`.
- Reset mid-operation drops in-flight writes and pending read valids. The parent must reset the FIFO (async active-low) in the same cycle.
- Write latency: `oAck` at cycle t → `oEn[1]` at t+1 → RAM written at the t+1 edge.
- Read latency: `oRdAck` at t → `oEn[0]` at t+1 → FIFO `oData` updated at the t+1 edge → `oRdValid=1` at t+2.
- `oRdValid` is a 2-stage pipeline of `oRdAck`. Back-to-back accepts give back-to-back valids.
- Write-to-read: a word granted at t may be read-accepted at t+1; its data appears with `oRdValid` at t+3.
- Sustained throughput: one write plus one read per cycle.

## Configuration
- `FIFO_ARB_FIXPRIO_EN` defined: fixed priority. Producer 0 always wins; `rr` is not implemented. Producer 1 is granted only when `iReq[0]=0`.
- `FIFO_ARB_FIXPRIO_EN` undefined (default): round-robin as described above.

## Test plan
- Reset, then `iReq=2'b01` with `iData0=8'hA5` for 1 cycle, then `iRdReq` pulsed → `oAck=01`; `oEn[1]` next cycle; `oRdValid=1` with `oRdData=8'hA5` two cycles after `oRdAck`; `oCount` returns to 0.
- `iReq=2'b11` held, `iData0=8'h10`, `iData1=8'h20`, requesters de-asserting after their ack → grants in order 0, 1; readback order is `8'h10`, `8'h20`.
  - With `FIFO_ARB_FIXPRIO_EN` and `iReq[0]` held continuously, producer 1 receives no grant.
- Continuous writes of 0..19 with no reads → exactly 16 acks; `oCount=16`; `iTag[1]=1`; `oErr=0`. Then 16 reads return 0..15 in order; `iTag[0]=1`.
- At `oCount=16`, assert `iReq[0]` and `iRdReq` together → `oRdAck=1`, `oAck=0` that cycle, `oCount=15`; the write is granted next cycle.
- At `oCount=0`, hold `iRdReq` with a single write → no `oRdAck` until the cycle after the grant; never `oErr`.
- Assert `RESET` while a read is in flight (`oRdAck` one cycle earlier) → `oRdValid` stays 0; `oCount=0`, `oEn=0` after the edge.
